// File: rtl/dds_sweep_sequencer.sv
// Frequency-sweep sequencer: walks a range of the coarse increment table,
// presenting each entry to the DDS for a programmable dwell, in single/loop/ping-pong mode.
module dds_sweep_sequencer #(
    parameter int INC_WIDTH   = 32,
    parameter int IDX_WIDTH   = 4,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [1:0]             i_mode,
    input  logic [IDX_WIDTH-1:0]   i_idx_first,
    input  logic [IDX_WIDTH-1:0]   i_idx_last,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    input  logic [INC_WIDTH-1:0]   i_rom_incremento_grueso [2**IDX_WIDTH],
    output logic [INC_WIDTH-1:0]   o_incremento,
    output logic                   o_inc_load,
    output logic [IDX_WIDTH-1:0]   o_idx,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_DONE} state_t;

    localparam logic [1:0] MODE_LOOP = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [IDX_WIDTH-1:0]   first_q, first_d;
    logic [IDX_WIDTH-1:0]   last_q, last_d;
    logic [1:0]             mode_q, mode_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic                   dir_up_q, dir_up_d;
    logic [INC_WIDTH-1:0]   inc_q, inc_d;
    logic [IDX_WIDTH-1:0]   idx_out_q, idx_out_d;
    logic                   load_q, load_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        first_d   = first_q;
        last_d    = last_q;
        mode_d    = mode_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        dir_up_d  = dir_up_q;
        inc_d     = inc_q;
        idx_out_d = idx_out_q;
        load_d    = 1'b0;
        done_d    = 1'b0;

        // Abort wins over any step, load or done in the same cycle.
        if (i_stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else if (i_enable) begin
            case (state_q)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        first_d  = i_idx_first;
                        last_d   = i_idx_last;
                        mode_d   = i_mode;
                        dwell_d  = (i_dwell == '0) ? DWELL_WIDTH'(1) : i_dwell;
                        dir_up_d = (i_idx_first <= i_idx_last);
                        idx_d    = i_idx_first;
                        state_d  = S_LOAD;
                    end
                end
                S_LOAD: begin
                    inc_d     = i_rom_incremento_grueso[idx_q];
                    idx_out_d = idx_q;
                    load_d    = 1'b1;
                    cnt_d     = dwell_q - DWELL_WIDTH'(1);
                    state_d   = S_DWELL;
                end
                S_DWELL: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_WIDTH'(1);
                    end else if (idx_q != last_q) begin
                        idx_d   = dir_up_q ? idx_q + IDX_WIDTH'(1) : idx_q - IDX_WIDTH'(1);
                        state_d = S_LOAD;
                    end else if (mode_q == MODE_LOOP) begin
                        idx_d   = first_q;
                        state_d = S_LOAD;
                    end else if (mode_q == MODE_PING) begin
                        // Bounce: the old first becomes the new end point.
                        first_d  = last_q;
                        last_d   = first_q;
                        dir_up_d = !dir_up_q;
                        if (first_q != last_q)
                            idx_d = dir_up_q ? idx_q - IDX_WIDTH'(1) : idx_q + IDX_WIDTH'(1);
                        state_d  = S_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_DWELL);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            first_q   <= '0;
            last_q    <= '0;
            mode_q    <= '0;
            dwell_q   <= '0;
            cnt_q     <= '0;
            dir_up_q  <= 1'b0;
            inc_q     <= '0;
            idx_out_q <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            last_q    <= last_d;
            mode_q    <= mode_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            dir_up_q  <= dir_up_d;
            inc_q     <= inc_d;
            idx_out_q <= idx_out_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_incremento = inc_q;
    assign o_inc_load   = load_q;
    assign o_idx        = idx_out_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_dds_sweep_sequencer.sv
// Bench for dds_sweep_sequencer: directed and randomized sweeps checked cycle by cycle
// against a timeline model built from step counts, dwell lengths and index paths.
module tb_dds_sweep_sequencer;

    localparam int NONE = 1000;

    logic        clk = 1'b0;
    always #4 clk = ~clk;

    logic        rst_n, en, start, stop;
    logic [1:0]  mode;
    logic [3:0]  f, l;
    logic [15:0] dw;
    logic [31:0] tab [16];
    logic [31:0] o_inc;
    logic        o_load, o_busy, o_done;
    logic [3:0]  o_idx;

    dds_sweep_sequencer #(.INC_WIDTH(32), .IDX_WIDTH(4), .DWELL_WIDTH(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_start(start), .i_stop(stop),
        .i_mode(mode), .i_idx_first(f), .i_idx_last(l), .i_dwell(dw),
        .i_rom_incremento_grueso(tab),
        .o_incremento(o_inc), .o_inc_load(o_load), .o_idx(o_idx),
        .o_busy(o_busy), .o_done(o_done)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic        e_load [256];
    logic        e_busy [256];
    logic        e_done [256];
    logic [31:0] e_inc  [256];
    logic [3:0]  e_idx  [256];
    logic [31:0] m_inc = '0;
    logic [3:0]  m_idx = '0;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, exp);
        end
    endtask

    task automatic chk_all(input int c);
        chk("inc_load", c, 32'(o_load), 32'(e_load[c]));
        chk("busy",     c, 32'(o_busy), 32'(e_busy[c]));
        chk("done",     c, 32'(o_done), 32'(e_done[c]));
        chk("incremento", c, o_inc, e_inc[c]);
        chk("idx",      c, 32'(o_idx), 32'(e_idx[c]));
    endtask

    // Timeline model: step k occupies cycles L..L+dwell with L = 1 + k*(dwell+1),
    // its value appears one cycle after L; stop/reset truncate the timeline.
    task automatic build(input int first, input int last, input int md, input int dwell,
                         input int stop_c, input int rst_c, input int ncyc);
        int         dl, n, pos, idx, lc;
        bit         single;
        logic [3:0] ldi [256];
        dl     = (dwell == 0) ? 1 : dwell;
        n      = (first <= last) ? last - first + 1 : first - last + 1;
        single = (md == 0) || (md == 3);
        for (int c = 0; c < 256; c++) begin
            e_load[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0; ldi[c] = '0;
        end
        for (int k = 0; k < 256; k++) begin
            lc = 1 + k * (dl + 1);
            if (lc > ncyc) break;
            if (single && k == n) begin
                e_done[lc] = 1'b1;
                break;
            end
            if (md == 1) pos = k % n;
            else if (md == 2 && n > 1) begin
                pos = k % (2 * n - 2);
                if (pos >= n) pos = 2 * n - 2 - pos;
            end else if (md == 2) pos = 0;
            else pos = k;
            idx = (first <= last) ? first + pos : first - pos;
            for (int j = 0; j <= dl; j++)
                if (lc + j <= ncyc) e_busy[lc + j] = 1'b1;
            if (lc + 1 <= ncyc) begin
                e_load[lc + 1] = 1'b1;
                ldi[lc + 1]    = 4'(idx);
            end
        end
        for (int c = 0; c <= ncyc; c++) begin
            if (c > stop_c || c > rst_c) begin
                e_load[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0;
            end
            if (c > rst_c) begin
                m_inc = '0; m_idx = '0;
            end
            if (e_load[c]) begin
                m_idx = ldi[c];
                m_inc = tab[ldi[c]];
            end
            e_inc[c] = m_inc;
            e_idx[c] = m_idx;
        end
    endtask

    task automatic run(input int first, input int last, input int md, input int dwell,
                       input int stop_c, input int rst_c, input int ncyc, input bit noisy);
        build(first, last, md, dwell, stop_c, rst_c, ncyc);
        f = 4'(first); l = 4'(last); mode = 2'(md); dw = 16'(dwell);
        start = 1'b1; stop = 1'b0;
        chk_all(0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            chk_all(c);
            start = noisy && e_busy[c] && ($urandom_range(0, 2) == 0);
            stop  = (c == stop_c);
            rst_n = (c != rst_c);
            if (noisy) begin
                f = 4'($urandom); l = 4'($urandom); mode = 2'($urandom); dw = 16'($urandom_range(0, 9));
            end
        end
        start = 1'b0; stop = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        int fi, la, md, dwl, dl, n, ncyc, stp, rst;
        rst_n = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0;
        mode = '0; f = '0; l = '0; dw = '0;
        for (int i = 0; i < 16; i++) tab[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        tab[0]  = 32'h0000_8638; tab[1]  = 32'h0000_C898; tab[2]  = 32'h0001_2B1C;
        tab[3]  = 32'h0001_C108; tab[5]  = 32'h0003_EE29; tab[13] = 32'h0062_B7BE;
        tab[14] = 32'h0095_0A8B; tab[15] = 32'h020A_1F1A;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_incremento", 0, o_inc, 32'h0);
        chk("rst_idx",  0, 32'(o_idx),  32'h0);
        chk("rst_load", 0, 32'(o_load), 32'h0);
        chk("rst_busy", 0, 32'(o_busy), 32'h0);
        chk("rst_done", 0, 32'(o_done), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 3, 0, 4, NONE, NONE, 22, 1'b0);    // single up, done at 21
        run(15, 13, 0, 1, NONE, NONE, 8, 1'b0);   // single down, done at 7
        run(2, 3, 1, 2, 11, NONE, 13, 1'b1);      // loop, stop mid-dwell, busy starts ignored
        run(0, 2, 2, 1, 16, NONE, 18, 1'b0);      // ping-pong 0,1,2,1,0,1,2
        run(5, 5, 2, 1, 10, NONE, 12, 1'b0);      // ping-pong on a single entry
        run(4, 6, 0, 0, NONE, NONE, 8, 1'b0);     // dwell 0 behaves as 1
        run(1, 4, 1, 2, 9, NONE, 11, 1'b1);       // stop then
        run(1, 4, 1, 2, NONE, 9, 11, 1'b1);       // reset mid-sweep

        // start while disabled must not launch a sweep
        en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk("dis_start_busy", 0, 32'(o_busy), 32'h0);
        chk("dis_start_load", 0, 32'(o_load), 32'h0);
        start = 1'b0; en = 1'b1;
        @(posedge clk); #1;

        // enable low for 5 cycles in the first dwell stretches that step to 9 cycles
        f = 4'd0; l = 4'd1; mode = 2'd0; dw = 16'd3; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            chk("en_load", c, 32'(o_load), 32'(c == 2 || c == 11));
            chk("en_busy", c, 32'(o_busy), 32'(c >= 1 && c <= 13));
            chk("en_done", c, 32'(o_done), 32'(c == 14));
            if (c >= 2) chk("en_incremento", c, o_inc, (c < 11) ? tab[0] : tab[1]);
            en = !(c >= 3 && c <= 7);
        end
        m_inc = tab[1]; m_idx = 4'd1;

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 16; i++) tab[i] = $urandom;
            fi = $urandom_range(0, 15); la = $urandom_range(0, 15);
            md = $urandom_range(0, 3);  dwl = $urandom_range(0, 4);
            dl = (dwl == 0) ? 1 : dwl;
            n  = (fi <= la) ? la - fi + 1 : fi - la + 1;
            stp = NONE; rst = NONE;
            if (md == 0 || md == 3) begin
                ncyc = 2 + n * (dl + 1);
                if ($urandom_range(0, 2) == 0) begin
                    stp  = $urandom_range(1, ncyc - 1);
                    ncyc = stp + 2;
                end
            end else begin
                ncyc = $urandom_range(8, 60);
                if ($urandom_range(0, 3) == 0) rst = ncyc - 2;
                else stp = ncyc - 2;
            end
            run(fi, la, md, dwl, stp, rst, ncyc, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dds_sweep_sequencer.md
# dds_sweep_sequencer

Frequency-sweep controller for the DDS core. On a start pulse it steps the phase increment through a range of the 16-entry coarse increment table, holding each value for a programmable dwell time. It drives the DDS phase-accumulator increment with a one-cycle load strobe, in single, loop or ping-pong mode. It sits between the button/control logic, which supplies range, mode and dwell, and the DDS datapath, which consumes `o_incremento`.

## Interface

Parameters:
- `INC_WIDTH`, 32, width of each table entry and of `o_incremento`.
- `IDX_WIDTH`, 4, table index width (table depth is 2**IDX_WIDTH = 16).
- `DWELL_WIDTH`, 16, dwell counter width.

Ports:
- `i_clk`  in  1  system clock, 125 MHz; single clock domain.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_enable`  in  1  global clock enable; low freezes all state.
- `i_start`  in  1  start pulse; sampled only in IDLE.
- `i_stop`  in  1  abort pulse; highest priority after reset.
- `i_mode`  in  2  sweep mode: 00 single, 01 loop, 10 ping-pong, 11 treated as single.
- `i_idx_first`  in  IDX_WIDTH  first table index.
- `i_idx_last`  in  IDX_WIDTH  last table index.
- `i_dwell`  in  DWELL_WIDTH  dwell per step in cycles; 0 is treated as 1.
- `i_rom_incremento_grueso`  in  [16] x INC_WIDTH  coarse increment table (unpacked array).
- `o_incremento`  out  INC_WIDTH  current phase increment to the DDS.
- `o_inc_load`  out  1  one-cycle strobe, high in the first cycle of a new `o_incremento` value.
- `o_idx`  out  IDX_WIDTH  table index of the current `o_incremento`.
- `o_busy`  out  1  high in LOAD and DWELL.
- `o_done`  out  1  one-cycle pulse at the end of a single sweep.

## Operation

- **Reset values:** state IDLE; `o_incremento`=0, `o_idx`=0, `o_inc_load`=0, `o_busy`=0, `o_done`=0.
- **States:** IDLE, LOAD, DWELL, DONE. All outputs are registered.
- **IDLE**
  - When `i_start` & `i_enable`: latch first, last, mode and dwell (dwell_l = max(`i_dwell`,1)); set idx=first; go to LOAD.
  - Direction is up if first ≤ last, otherwise down.
- **LOAD** (1 cycle)
  - At the exiting edge: `o_incremento` ← table[idx], `o_idx` ← idx, `o_inc_load` ← 1, counter ← dwell_l−1.
  - Go to DWELL.
- **DWELL**
  - If counter ≠ 0: decrement.
  - If counter = 0 and idx ≠ last: idx steps ±1 in the current direction; go to LOAD.
  - If counter = 0 and idx = last:
    - single: go to DONE.
    - loop: idx=first; go to LOAD.
    - ping-pong: swap the latched first/last, reverse direction, step idx one toward the new last; go to LOAD. If first = last, idx is unchanged.
- **DONE** (1 cycle): `o_done`=1, `o_busy`=0; go to IDLE.
- **Held values:** `o_incremento` and `o_idx` keep their last value in IDLE and DONE. Only LOAD, or reset, changes them.
- **`i_stop`:** in LOAD, DWELL or DONE, go to IDLE at the next edge. No `o_done` pulse and no load; `o_incremento` is held. Stop beats a same-cycle step or load.
- **`i_start` while not IDLE:** ignored.
- **`i_start` and `i_stop` together in IDLE:** the sweep does not start.
- **`i_enable`=0:** state, counter and idx freeze, and `o_inc_load`/`o_done` are forced to 0. `o_busy` reflects the frozen state. Each disabled cycle adds one cycle to the current step.
- **Latched parameters:** input changes during a sweep have no effect until the next start. The table input is read live at each LOAD.
- **Reset mid-sweep:** all registers return to their reset values at the next edge. No done pulse.

## Timing

- `i_start` high in cycle 0 → LOAD in cycle 1 → `o_inc_load`=1 and `o_incremento`=table[first] in cycle 2.
- Load strobes are spaced dwell_l+1 cycles apart (1 LOAD cycle + dwell_l DWELL cycles).
- Single sweep of N steps:
  - k-th load (k = 0..N−1) at cycle 2+k·(dwell_l+1).
  - `o_done` at cycle 2+(N−1)(dwell_l+1)+dwell_l−1+1 = 1+N·(dwell_l+1)... equivalently 2+(N−1)(dwell_l+1)+dwell_l.
  - Back in IDLE the following cycle.
- Stop issued in cycle s → `o_busy`=0 in cycle s+1.
- With first=last, single mode: one load, then `o_done` dwell_l cycles later.

## Test plan

- **Single up:** table loaded as in the production DDS (0x00008638, 0x0000C898, 0x00012B1C, 0x0001C108, …); first=0, last=3, dwell=4, start at cycle 0 → loads at cycles 2/7/12/17 with those four values; `o_done` at cycle 21; `o_incremento` stays 0x0001C108.
- **Single down:** first=15, last=13, dwell=1 → loads 0x020A1F1A, 0x00950A8B, 0x0062B7BE at cycles 2/4/6; `o_done` at cycle 7.
- **Loop and stop:** first=2, last=3, dwell=2 → idx sequence 2,3,2,3, one load every 3 cycles. `i_stop` mid-dwell → `o_busy` low the next cycle, no `o_done`, `o_incremento` held.
- **Ping-pong:** first=0, last=2, dwell=1 → idx 0,1,2,1,0,1,2; `o_busy` stays high. Also first=last=5 → table[5]=0x0003EE29 reloaded every 2 cycles.
- **Enable and dwell=0:** `i_enable` low 5 cycles in DWELL (dwell=3) → that step lasts 9 cycles, with no strobe while low. dwell=0 → behaves as dwell=1.
- **Reset and start robustness:** `i_rst_n` low mid-sweep → all outputs 0 at the next edge. `i_start` pulses while busy → ignored, and the sequence is unchanged.
